// File: rtl/cwc_host_ctrl.sv
// cwc_host_ctrl: host-side command engine for the ChipWatcher debug hub.
//
// Parses a byte-stream command protocol from the host link and drives the
// hub control vector / reset pulse, or returns the hub status vector.
//   0x01 WRITE_CTRL + CB payload bytes (LSB byte first) -> ACK 0xA5
//   0x02 READ_STAT                                     -> SB status bytes (LSB first)
//   0x03 HUB_RESET  (RST_CYCLES-cycle cwc_rst pulse)   -> ACK 0xA5
//   other opcode, or payload stall of TIMEOUT_CYC idle cycles -> NAK 0xEE
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   rx_data/rx_valid/rx_ready  command/payload byte stream from host
//   tx_data/tx_valid/tx_ready  response byte stream to host
//   control                  hub control vector (updates atomically)
//   status                   hub status vector (sampled only on READ_STAT accept)
//   cwc_rst                  active-high hub reset pulse
//   busy                     FSM not idle
module cwc_host_ctrl #(
   parameter int CTRL_LEN    = 50,
   parameter int STAT_LEN    = 24,
   parameter int RST_CYCLES  = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic                rx_ready,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic [CTRL_LEN-1:0] control,
   input  logic [STAT_LEN-1:0] status,
   output logic                cwc_rst,
   output logic                busy
);

   localparam int CB    = (CTRL_LEN + 7) / 8;
   localparam int SB    = (STAT_LEN + 7) / 8;
   localparam int MAXB  = (CB > SB) ? CB : SB;
   localparam int CNT_W = $clog2(MAXB) + 1;
   // The idle/timeout counter doubles as the reset-pulse counter, so it is
   // sized for whichever of the two limits is larger.
   localparam int TMAX  = (TIMEOUT_CYC > RST_CYCLES) ? TIMEOUT_CYC : RST_CYCLES;
   localparam int TO_W  = $clog2(TMAX + 1);

   localparam logic [7:0] ACK = 8'hA5;
   localparam logic [7:0] NAK = 8'hEE;

   typedef enum logic [1:0] {IDLE, WR_DATA, SEND, RST_PULSE} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;     // payload byte index / tx byte index
   logic [CNT_W-1:0]    last_q, last_d;   // index of last response byte
   logic [TO_W-1:0]     to_q, to_d;
   logic [CTRL_LEN-1:0] wr_sh_q, wr_sh_d; // payload shadow, committed atomically
   logic [SB*8-1:0]     resp_q, resp_d;   // response byte queue
   logic [CTRL_LEN-1:0] control_q, control_d;
   logic                rst_q, rst_d;
   logic [SB*8-1:0]     stat_ext;
   logic                rx_fire, tx_fire;

   assign rx_ready = (state_q == IDLE) || (state_q == WR_DATA);
   assign tx_valid = (state_q == SEND);
   assign rx_fire  = rx_valid & rx_ready;
   assign tx_fire  = tx_valid & tx_ready;
   assign busy     = (state_q != IDLE);
   assign control  = control_q;
   assign cwc_rst  = rst_q;
   assign tx_data  = tx_valid ? resp_q[8*int'(cnt_q) +: 8] : 8'h00;

   // Status zero-extended to whole bytes.
   always_comb begin
      stat_ext = '0;
      stat_ext[STAT_LEN-1:0] = status;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      to_d      = to_q;
      wr_sh_d   = wr_sh_q;
      resp_d    = resp_q;
      control_d = control_q;
      rst_d     = rst_q;
      case (state_q)
         IDLE: begin
            if (rx_fire) begin
               cnt_d = '0;
               to_d  = '0;
               case (rx_data)
                  8'h01: state_d = WR_DATA;
                  8'h02: begin
                     resp_d  = stat_ext;
                     last_d  = CNT_W'(SB - 1);
                     state_d = SEND;
                  end
                  8'h03: begin
                     rst_d   = 1'b1;
                     state_d = RST_PULSE;
                  end
                  default: begin
                     resp_d      = '0;
                     resp_d[7:0] = NAK;
                     last_d      = '0;
                     state_d     = SEND;
                  end
               endcase
            end
         end
         WR_DATA: begin
            if (rx_fire) begin
               // Bits of the last byte above CTRL_LEN are simply not stored.
               for (int b = 0; b < 8; b++) begin
                  if (8*int'(cnt_q) + b < CTRL_LEN) wr_sh_d[8*int'(cnt_q) + b] = rx_data[b];
               end
               to_d = '0;
               if (cnt_q == CNT_W'(CB - 1)) begin
                  control_d   = wr_sh_d;
                  resp_d      = '0;
                  resp_d[7:0] = ACK;
                  last_d      = '0;
                  cnt_d       = '0;
                  state_d     = SEND;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
               // This idle cycle is the TIMEOUT_CYC-th: abort, control untouched.
               resp_d      = '0;
               resp_d[7:0] = NAK;
               last_d      = '0;
               cnt_d       = '0;
               state_d     = SEND;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         RST_PULSE: begin
            if (to_q == TO_W'(RST_CYCLES - 1)) begin
               rst_d       = 1'b0;
               resp_d      = '0;
               resp_d[7:0] = ACK;
               last_d      = '0;
               cnt_d       = '0;
               state_d     = SEND;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         SEND: begin
            if (tx_fire) begin
               if (cnt_q == last_q) state_d = IDLE;
               else                 cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_q    <= '0;
         to_q      <= '0;
         wr_sh_q   <= '0;
         resp_q    <= '0;
         control_q <= '0;
         rst_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         to_q      <= to_d;
         wr_sh_q   <= wr_sh_d;
         resp_q    <= resp_d;
         control_q <= control_d;
         rst_q     <= rst_d;
      end
   end

endmodule

// File: tb/tb_cwc_host_ctrl.sv
// Self-checking bench for cwc_host_ctrl: directed protocol cases plus a
// randomized command mix checked against a byte-level reference model.
module tb_cwc_host_ctrl;
   localparam int CL = 50;
   localparam int SL = 24;
   localparam int RC = 4;
   localparam int TO = 16;
   localparam int CB = 7;
   localparam int SB = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [CL-1:0] control;
   logic [SL-1:0] status;
   logic          cwc_rst;
   logic          busy;

   always #5 clk = ~clk;

   cwc_host_ctrl #(.CTRL_LEN(CL), .STAT_LEN(SL), .RST_CYCLES(RC), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .control(control), .status(status), .cwc_rst(cwc_rst), .busy(busy)
   );

   int            n_chk = 0;
   int            n_fail = 0;
   logic [7:0]    got_q[$];
   logic [7:0]    exp_q[$];
   logic [7:0]    pay[CB];
   logic [CL-1:0] ctrl_m;       // model of the committed control vector
   int            mode;         // tx_ready: 0 high, 1 random, 2 toggle, 3 low
   logic          pend;
   logic [7:0]    pend_d;
   logic [CL-1:0] s_ctrl;
   logic          s_txv, s_busy, s_rdy, s_cwc, acc;
   logic [7:0]    s_txd;
   int            cwc_hi, busy_rdy;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: sample at negedge, log tx handshakes, check stall stability,
   // then drive tx_ready just after the posedge.
   task automatic tick();
      @(negedge clk);
      s_ctrl = control; s_txv = tx_valid; s_txd = tx_data;
      s_busy = busy;    s_rdy = rx_ready; s_cwc = cwc_rst;
      acc = rx_valid && rx_ready;
      if (s_cwc) cwc_hi++;
      if (s_busy && s_rdy) busy_rdy++;
      if (!rst_n) pend = 1'b0;
      else begin
         if (pend) chk("tx_hold", {s_txv, s_txd}, {1'b1, pend_d});
         if (s_txv && tx_ready) begin got_q.push_back(s_txd); pend = 1'b0; end
         else if (s_txv) begin pend = 1'b1; pend_d = s_txd; end
         else pend = 1'b0;
      end
      @(posedge clk);
      #1;
      case (mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = 1'($urandom_range(0, 1));
         2:       tx_ready = ~tx_ready;
         default: tx_ready = 1'b0;
      endcase
   endtask

   task automatic put(input logic [7:0] b);
      int n = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      do begin tick(); n++; end while (!acc && n < 50);
      if (!acc) chk("rx_accept", 0, 1);
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      do begin tick(); n++; end while ((s_busy || s_txv) && n < 300);
      if (n >= 300) chk({tag, "_idle_timeout"}, 0, 1);
   endtask

   task automatic cmp_resp(input string tag);
      chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk({tag, "_byte"}, got_q[i], exp_q[i]);
      chk({tag, "_ctrl"}, s_ctrl, ctrl_m);
   endtask

   task automatic do_write(input string tag, input int gapmax);
      logic [63:0] nv = '0;
      for (int i = 0; i < CB; i++) nv = nv | (64'(pay[i]) << (8 * i));
      got_q.delete(); exp_q.delete(); exp_q.push_back(8'hA5);
      put(8'h01);
      for (int i = 0; i < CB; i++) begin
         repeat ($urandom_range(0, gapmax)) tick();
         put(pay[i]);
      end
      chk({tag, "_ctrl_before"}, s_ctrl, ctrl_m);
      ctrl_m = nv[CL-1:0];
      tick();
      chk({tag, "_ctrl_new"}, s_ctrl, ctrl_m);
      chk({tag, "_ack_same_cycle"}, {s_txv, s_txd}, {1'b1, 8'hA5});
      wait_idle(tag);
      cmp_resp(tag);
   endtask

   task automatic do_read(input string tag, input logic [SL-1:0] st, input logic [SL-1:0] st_after);
      got_q.delete(); exp_q.delete();
      for (int i = 0; i < SB; i++) exp_q.push_back(8'((st >> (8 * i)) & 24'hFF));
      status = st;
      put(8'h02);
      status = st_after;
      tick();
      chk({tag, "_first_valid"}, {s_txv, s_txd}, {1'b1, exp_q[0]});
      wait_idle(tag);
      cmp_resp(tag);
   endtask

   task automatic do_hub(input string tag);
      got_q.delete(); exp_q.delete(); exp_q.push_back(8'hA5);
      cwc_hi = 0; busy_rdy = 0;
      put(8'h03);
      chk({tag, "_cwc_before"}, s_cwc, 0);
      tick();
      chk({tag, "_cwc_rise"}, s_cwc, 1);
      wait_idle(tag);
      chk({tag, "_cwc_len"}, cwc_hi, RC);
      chk({tag, "_rdy_low"}, busy_rdy, 0);
      cmp_resp(tag);
   endtask

   task automatic do_bad(input string tag, input logic [7:0] op);
      got_q.delete(); exp_q.delete(); exp_q.push_back(8'hEE);
      put(op);
      wait_idle(tag);
      cmp_resp(tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int sel;
      logic [7:0] op;
      mode = 0; pend = 1'b0; cwc_hi = 0; busy_rdy = 0; ctrl_m = '0;
      tx_ready = 1'b1; status = '0;
      rst_n = 1'b0; rx_valid = 1'b1; rx_data = 8'h01;
      tick(); tick();
      chk("rst_control", s_ctrl, 0);
      chk("rst_txv", s_txv, 0);
      chk("rst_txd", s_txd, 0);
      chk("rst_cwc", s_cwc, 0);
      chk("rst_busy", s_busy, 0);
      chk("rst_rdy", s_rdy, 1);
      rx_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("post_rst_idle", {s_busy, s_rdy}, 2'b01);

      // Directed WRITE_CTRL: upper 6 bits of the final 0xFF fall off.
      pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hFF};
      do_write("wr_dir", 0);
      chk("wr_dir_const", control, 50'h3_6655_4433_2211);

      do_read("rd_dir", 24'hABCDEF, 24'h0);
      mode = 2; tx_ready = 1'b1;
      do_read("rd_toggle", 24'hABCDEF, 24'h0);
      mode = 0;

      do_hub("hub_dir");

      // Payload stall: NAK after TO idle cycles, control keeps old value.
      got_q.delete(); exp_q.delete(); exp_q.push_back(8'hEE);
      put(8'h01);
      put(8'h12);
      n = 0;
      do begin tick(); n++; end while (!s_txv && n < 100);
      chk("to_latency", n, TO + 1);
      wait_idle("to");
      cmp_resp("to");

      do_bad("bad_7f", 8'h7F);

      // Async reset in the middle of a stalled READ_STAT response.
      mode = 3; tx_ready = 1'b0;
      status = 24'h123456;
      put(8'h02);
      repeat (3) tick();
      rst_n = 1'b0;
      #2;
      chk("rst_mid_txv", tx_valid, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_rdy", rx_ready, 1);
      chk("rst_mid_ctrl", control, 0);
      ctrl_m = '0;
      tick(); tick();
      rst_n = 1'b1;
      mode = 0; tx_ready = 1'b1;
      tick();
      do_read("rd_after_rst", 24'h5A0FC3, 24'hFFFFFF);

      // Randomized command mix.
      for (int it = 0; it < 40; it++) begin
         mode = $urandom_range(0, 1);
         sel  = $urandom_range(0, 3);
         case (sel)
            0: begin
               for (int i = 0; i < CB; i++) pay[i] = 8'($urandom);
               do_write("rnd_wr", 12);
            end
            1: do_read("rnd_rd", SL'($urandom), SL'($urandom));
            2: do_hub("rnd_hub");
            default: begin
               do op = 8'($urandom); while (op inside {8'h01, 8'h02, 8'h03});
               do_bad("rnd_bad", op);
            end
         endcase
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
